sr_fetch: RTL and testbench
===========================

SR_FETCH -- requirements
Module: sr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imAddr  output  32  instruction memory request address (word-aligned).
REQ-005 SHALL have port imReq  output  1  instruction memory request valid.
REQ-006 SHALL have port imGnt  input  1  memory accepts request this cycle (transfer = imReq & imGnt).
REQ-007 SHALL have port imRvalid  input  1  read data valid, in request order, at least 1 cycle after grant.
REQ-008 SHALL have port imRdata  input  32  read instruction word.
REQ-009 SHALL have port redirect  input  1  branch/jump taken: restart fetch.
REQ-010 SHALL have port redirectPc  input  32  restart address; bits [1:0] ignored (treated as 0).
REQ-011 SHALL have port instrValid  output  1  instr/instrPc valid to the decode stage.
REQ-012 SHALL have port instrReady  input  1  decode consumes (transfer = instrValid & instrReady).
REQ-013 SHALL have port instr  output  32  instruction word for the decoder.
REQ-014 SHALL have port instrPc  output  32  address of instr.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, FLUSH; BOOT -> RUN after one cycle; RUN -> FLUSH on redirect with outstanding responses; RUN on redirect with none stays RUN; FLUSH -> RUN when discard count reaches 0.
REQ-016 SHALL hold fetch PC register; imAddr = PC; PC += 4 on each transfer (32-bit wrap, FFFF_FFFC -> 0000_0000).
REQ-017 SHALL assert imReq only in RUN, only when no redirect this cycle, and only when (free buffer slots) > (outstanding requests).
REQ-018 SHALL track outstanding requests (0..DEPTH): +1 on grant, -1 on imRvalid, both same cycle = unchanged.
REQ-019 SHALL write imRdata and its PC into the instruction buffer on imRvalid unless discarding; instrValid asserts the cycle after imRvalid (1-cycle latency).
REQ-020 SHALL present buffer head on instr/instrPc; pop on decode transfer; instr = 32'h0000_0013 (NOP) whenever instrValid = 0.
REQ-021 SHALL on redirect: load PC = {redirectPc[31:2],2'b00}, empty the buffer next cycle, set discard count = outstanding after this cycle's grant/rvalid updates; each later imRvalid decrements it and is dropped.
REQ-022 SHALL complete a decode transfer occurring in the redirect cycle (instr consumed) before flushing.
REQ-023 SHALL count a grant in the redirect cycle as stale (discarded); none can occur as imReq is low then.
REQ-024 SHALL treat redirect in FLUSH as a new redirect: PC reloaded, discard count keeps accumulating.
REQ-025 SHALL never overflow the buffer; imRvalid with no outstanding request is ignored.

Reset
REQ-026 SHALL on rst_n low immediately set: state BOOT, PC = RESET_PC, imAddr = RESET_PC, imReq = 0, instrValid = 0, instr = 32'h0000_0013, instrPc = 0, buffer empty, counters 0.
REQ-027 SHALL on reset mid-operation abandon all in-flight requests; responses arriving after release with no outstanding request are ignored.

Configuration
REQ-028 SHALL with SR_FETCH_SKID_EN defined use buffer DEPTH = 2 (up to 2 outstanding, back-to-back fetch at 1 instr/cycle with 1-cycle memory).
REQ-029 SHALL without SR_FETCH_SKID_EN use DEPTH = 1 (at most 1 outstanding, max 1 instr per 2 cycles); ports unchanged.

Structure
REQ-030 SHALL place NOP encoding, default RESET_PC, FSM state encodings and DEPTH selection in shared header sr_cpu.vh.
REQ-031 SHALL implement the buffer as sub-module sr_fetch_buf (sync FIFO with PC field, flush input).

Verification
REQ-032 SHALL check reset release, RESET_PC=0, imGnt=1, 1-cycle memory, instrReady=1 -> instrPc 0,4,8 on consecutive cycles (SKID_EN) / every other cycle (no SKID_EN).
REQ-033 SHALL check instrReady=0 for 5 cycles -> imReq drops once buffer + outstanding = DEPTH; no instr lost; order 0,4,8 preserved.
REQ-034 SHALL check redirect to 32'h0000_0103 with 2 outstanding -> both stale words dropped, next instrPc = 32'h0000_0100.
REQ-035 SHALL check redirect coinciding with decode transfer of PC 8 -> PC 8 consumed once, next instrPc = redirect target.
REQ-036 SHALL check PC FFFF_FFFC fetched -> next imAddr 0000_0000.
REQ-037 SHALL check rst_n low with 1 outstanding, stale imRvalid after release -> ignored, first instrPc = RESET_PC.

Source files
------------

// File: rtl/sr_fetch_pkg.sv
// sr_fetch_pkg: shared CPU/fetch definitions.
//   - NOP encoding, default reset PC, fetch FSM state encoding
//   - instruction buffer depth, selected by macro SR_FETCH_SKID_EN
//     (defined: 2-entry buffer, back-to-back fetch; undefined: 1 entry)
//   - buffer entry struct (instruction word + its PC)
package sr_fetch_pkg;

    localparam logic [31:0] SR_NOP      = 32'h0000_0013;
    localparam logic [31:0] SR_RESET_PC = 32'h0000_0000;

`ifdef SR_FETCH_SKID_EN
    localparam int SR_FETCH_DEPTH = 2;
`else
    localparam int SR_FETCH_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

endpackage

// File: rtl/sr_fetch_buf.sv
// sr_fetch_buf: synchronous FIFO of {pc, instr} entries for the fetch stage.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           drop all entries at the next edge (wins over push)
//   wr_en, wr_data  push an entry (ignored when full)
//   rd_en           pop the head entry (ignored when empty)
//   rd_valid        head entry present
//   rd_data         head entry
//   count           current occupancy 0..DEPTH
module sr_fetch_buf
    import sr_fetch_pkg::*;
#(
    parameter  int DEPTH = SR_FETCH_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  fetch_ent_t       wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output fetch_ent_t       rd_data,
    output logic [CNT_W-1:0] count
);

    fetch_ent_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign push     = wr_en && (count != CNT_W'(DEPTH));
    assign pop      = rd_en && rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Data storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sr_fetch.sv
// sr_fetch: instruction fetch stage. Issues word-aligned requests to
// instruction memory, buffers in-order responses and hands them to decode.
// Redirects restart fetch; responses to requests issued before a redirect
// are counted and discarded. Buffer depth follows SR_FETCH_SKID_EN.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   imAddr/imReq/imGnt     memory request (transfer = imReq & imGnt)
//   imRvalid/imRdata       in-order read response
//   redirect/redirectPc    restart fetch at redirectPc (low 2 bits dropped)
//   instrValid/instrReady  decode handshake
//   instr/instrPc          buffered instruction and its address (NOP/0 when idle)
module sr_fetch
    import sr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = SR_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imAddr,
    output logic        imReq,
    input  logic        imGnt,
    input  logic        imRvalid,
    input  logic [31:0] imRdata,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] instrPc
);

    localparam int DEPTH = SR_FETCH_DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   wcnt_t;

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, rsp_pc, redir_pc;
    cnt_t         outst, outst_nxt, disc, disc_nxt, buf_cnt;
    wcnt_t        free_slots;
    logic         run_en, gnt_xfer, rv_eff, pop, buf_wr, buf_valid;
    fetch_ent_t   head, wr_ent;

    assign redir_pc = redirectPc & 32'hFFFF_FFFC;
    assign gnt_xfer = imReq && imGnt;
    // A response with nothing outstanding belongs to a request abandoned by reset.
    assign rv_eff   = imRvalid && (outst != '0);
    assign pop      = instrValid && instrReady;
    assign buf_wr   = rv_eff && (disc == '0);

    // A slot freed by this cycle's decode pop is already usable, which is
    // what lets a 2-entry buffer sustain one fetch per cycle.
    assign free_slots = wcnt_t'(DEPTH) - {1'b0, buf_cnt} + wcnt_t'(pop);
    assign imReq      = run_en && !redirect && (free_slots > {1'b0, outst});
    assign imAddr     = pc;

    assign outst_nxt = outst + cnt_t'(gnt_xfer) - cnt_t'(rv_eff);

    always_comb begin
        disc_nxt = disc;
        if (redirect)                 disc_nxt = outst_nxt;
        else if (rv_eff && disc != '0) disc_nxt = disc - 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_BOOT;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            default: state_nxt = (disc_nxt != '0) ? ST_FLUSH : ST_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run_en = (state == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
            outst  <= '0;
            disc   <= '0;
        end else begin
            outst <= outst_nxt;
            disc  <= disc_nxt;
            if (redirect)      pc <= redir_pc;
            else if (gnt_xfer) pc <= pc + 32'd4;
            // Kept responses arrive in order starting at the last restart address.
            if (redirect)      rsp_pc <= redir_pc;
            else if (buf_wr)   rsp_pc <= rsp_pc + 32'd4;
        end
    end

    assign wr_ent = '{pc: rsp_pc, instr: imRdata};

    sr_fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .wr_en    (buf_wr),
        .wr_data  (wr_ent),
        .rd_en    (pop),
        .rd_valid (buf_valid),
        .rd_data  (head),
        .count    (buf_cnt)
    );

    assign instrValid = buf_valid;
    assign instr      = buf_valid ? head.instr : SR_NOP;
    assign instrPc    = buf_valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_sr_fetch.sv
module tb_sr_fetch;

`ifdef SR_FETCH_SKID_EN
    localparam int TB_DEPTH = 2;
`else
    localparam int TB_DEPTH = 1;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk, rst_n, imGnt, imRvalid, redirect, instrReady;
    logic [31:0] imRdata, redirectPc;
    logic [31:0] imAddr, instr, instrPc;
    logic        imReq, instrValid;

    sr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imAddr(imAddr), .imReq(imReq), .imGnt(imGnt),
        .imRvalid(imRvalid), .imRdata(imRdata), .redirect(redirect),
        .redirectPc(redirectPc), .instrValid(instrValid), .instrReady(instrReady),
        .instr(instr), .instrPc(instrPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } memreq_t;
    typedef struct { logic [31:0] rpc; logic [31:0] exp_pc; logic [31:0] exp_next; } redir_vec_t;

    exp_t        expq[$];
    memreq_t     memq[$];
    logic [31:0] pop_pc[$];
    int          pop_cyc[$], grant_cyc[$];
    int          errors = 0, checks = 0, cyc = 0, mem_lat = 1;
    bit          gnt_en, rdy, mem_hold, last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock: drive at negedge, observe/score 1ns later, advance past posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!mem_hold && memq.size() > 0 && memq[0].due <= cyc) begin
            imRvalid = 1'b1;
            imRdata  = mdata(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imRvalid = 1'b0;
            imRdata  = 32'hDEAD_BEEF;
        end
        imGnt = gnt_en;
        instrReady = rdy;
        #1;
        last_req  = imReq && imGnt;
        last_addr = imAddr;
        if (redirect) chk("noreq_on_redirect", {31'b0, imReq}, 32'h0);
        if (imReq && imGnt) begin
            memq.push_back('{imAddr, cyc + mem_lat});
            expq.push_back('{imAddr, mdata(imAddr)});
            grant_cyc.push_back(cyc);
        end
        if (instrValid && instrReady) begin
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_instr: got pc %h, none expected", instrPc);
            end else begin
                e = expq.pop_front();
                chk("instrPc", instrPc, e.pc);
                chk("instr", instr, e.data);
            end
            pop_pc.push_back(instrPc);
            pop_cyc.push_back(cyc);
        end
        if (!instrValid) chk("nop_when_invalid", instr, NOP);
        if (redirect) expq.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_pop(input int idx, input string name, input logic [31:0] expv);
        for (int k = 0; k < 30 && pop_pc.size() <= idx; k++) tick();
        if (pop_pc.size() <= idx) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for instr, expected pc %h", name, expv);
        end else chk(name, pop_pc[idx], expv);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect = 1'b1; redirectPc = target;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        redir_vec_t vecs[4];
        int idx, n8;
        bit found;
        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0004};

        rst_n = 1'b0; imGnt = 1'b0; imRvalid = 1'b0; imRdata = '0;
        redirect = 1'b0; redirectPc = '0; instrReady = 1'b0;
        gnt_en = 1'b1; rdy = 1'b1; mem_hold = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_imReq", {31'b0, imReq}, 32'h0);
        chk("rst_imAddr", imAddr, RST_PC);
        chk("rst_instrValid", {31'b0, instrValid}, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_instrPc", instrPc, 32'h0);

        // Streaming after reset release
        rst_n = 1'b1;
        pop_pc.delete(); pop_cyc.delete(); grant_cyc.delete();
        for (int i = 0; i < 12; i++) tick();
        if (pop_pc.size() >= 3 && grant_cyc.size() >= 1) begin
            chk("stream_pc0", pop_pc[0], 32'h0);
            chk("stream_pc1", pop_pc[1], 32'h4);
            chk("stream_pc2", pop_pc[2], 32'h8);
            chk("stream_gap01", pop_cyc[1] - pop_cyc[0], TB_DEPTH == 2 ? 1 : 2);
            chk("stream_gap12", pop_cyc[2] - pop_cyc[1], TB_DEPTH == 2 ? 1 : 2);
            chk("first_latency", pop_cyc[0] - grant_cyc[0], 2);
        end else begin
            checks++; errors++;
            $display("FAIL stream_count: got %0d instrs expected >= 3", pop_pc.size());
        end

        // Decode stall: fetch must stop once buffer + outstanding fill up
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_imReq", {31'b0, last_req}, 32'h0);
        chk("stall_valid", {31'b0, instrValid}, 32'h1);
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Redirect with requests outstanding: stale words dropped
        mem_hold = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("outstanding_at_redirect", memq.size(), TB_DEPTH);
        do_redirect(32'h0000_0103);
        mem_hold = 1'b0;
        idx = pop_pc.size();
        wait_pop(idx, "redirect_target_pc", 32'h0000_0100);
        for (int i = 0; i < 4; i++) tick();

        // Redirect coinciding with decode transfer of PC 8
        rdy = 1'b0;
        do_redirect(32'h0);
        idx = pop_pc.size();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (instrValid && instrPc == 32'h8) found = 1'b1;
            else begin rdy = instrValid; tick(); end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL pc8_head: timeout, pc 8 never reached head");
        end else begin
            rdy = 1'b1;
            do_redirect(32'h0000_0200);
            wait_pop(pop_pc.size(), "after_pc8_target", 32'h0000_0200);
            n8 = 0;
            for (int i = idx; i < pop_pc.size(); i++) if (pop_pc[i] == 32'h8) n8++;
            chk("pc8_consumed_once", n8, 1);
        end

        // Table: redirect targets, alignment and PC wrap
        rdy = 1'b1; gnt_en = 1'b1;
        for (int v = 0; v < 4; v++) begin
            do_redirect(vecs[v].rpc);
            idx = pop_pc.size();
            for (int k = 0; k < 20; k++) begin
                tick();
                if (last_req) break;
            end
            chk("vec_fetch_addr", last_addr, vecs[v].exp_pc);
            tick();
            chk("vec_next_addr", last_addr, vecs[v].exp_next);
            wait_pop(idx, "vec_first_pc", vecs[v].exp_pc);
        end

        // Reset mid-flight with one outstanding request
        gnt_en = 1'b0;
        for (int k = 0; k < 10 && memq.size() != 0; k++) tick();
        for (int i = 0; i < 3; i++) tick();
        gnt_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (memq.size() >= 1) break;
        end
        gnt_en = 1'b0;
        mem_hold = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_imReq", {31'b0, imReq}, 32'h0);
        chk("arst_imAddr", imAddr, RST_PC);
        chk("arst_instrValid", {31'b0, instrValid}, 32'h0);
        chk("arst_instrPc", instrPc, 32'h0);
        expq.delete();
        tick(); tick();
        rst_n = 1'b1;
        mem_hold = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("stale_ignored_valid", {31'b0, instrValid}, 32'h0);
        gnt_en = 1'b1;
        idx = pop_pc.size();
        wait_pop(idx, "post_reset_first_pc", RST_PC);
        for (int i = 0; i < 6; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
